// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS control path:
//   - opcode constants for the supported instructions
//   - ALUOp, ALUSrcB and PCSource encodings
//   - controller state enum (state_e) and instruction-class enum (iclass_e)
// Optional feature macro: ILLEGAL_TRAP_EN (adds the HALT state).
// -----------------------------------------------------------------------------
package mips_pkg;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states. HALT only exists in the trapping build.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
`ifdef ILLEGAL_TRAP_EN
        ,
        S_HALT      = 4'd12
`endif
    } state_e;

    // Instruction classes used for the DECODE dispatch
    typedef enum logic [2:0] {
        CLS_MEM     = 3'd0,
        CLS_RTYPE   = 3'd1,
        CLS_ADDI    = 3'd2,
        CLS_BEQ     = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } iclass_e;

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundles the controller's datapath-facing signals.
//   Inputs to the controller : opcode, mem_ready
//   Outputs of the controller: PC/memory/IR/register-file/ALU strobes,
//                              instr_done, dbgState (current state, for debug)
//                              and illegal when ILLEGAL_TRAP_EN is defined.
// Handshake: MemRead/MemWrite are requests held stable until the memory
// answers with mem_ready=1 in the same cycle; that cycle completes the access.
// Modports: master = controller, slave = datapath/memory side.
// Optional feature macro: ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    import mips_pkg::*;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    state_e     dbgState;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, dbgState
`ifdef ILLEGAL_TRAP_EN
        , illegal
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, dbgState
`ifdef ILLEGAL_TRAP_EN
        , illegal
`endif
    );

endinterface

// File: rtl/opcode_class.sv
// -----------------------------------------------------------------------------
// opcode_class
// Purely combinational map from the 6-bit opcode to an instruction class.
//   opcode : in  6  instruction[31:26]
//   iclass : out    class code (iclass_e); unknown opcodes map to CLS_ILLEGAL
// lw and sw share CLS_MEM; they are told apart later in MEM_ADDR.
// -----------------------------------------------------------------------------
module opcode_class
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output iclass_e    iclass
);

    always_comb begin
        iclass = CLS_ILLEGAL;
        case (opcode)
            OP_LW,
            OP_SW:    iclass = CLS_MEM;
            OP_RTYPE: iclass = CLS_RTYPE;
            OP_ADDI:  iclass = CLS_ADDI;
            OP_BEQ:   iclass = CLS_BEQ;
            OP_J:     iclass = CLS_JUMP;
            default:  iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore sequencing FSM for the multi-cycle MIPS datapath. Each instruction is
// stepped through fetch, decode, execute, memory and write-back; the memory
// states stretch while mem_ready is low.
//   clk   : in  core clock, rising edge
//   rst_n : in  synchronous active-low reset
//   bus   : multicycle_control_if.master (opcode/mem_ready in, strobes out)
// All strobes are decoded from the state register. The only combinational
// qualifiers are rst_n (forces every strobe low), mem_ready (IRWrite/PCWrite
// in FETCH and instr_done in MEM_WRITE) and, in the non-trapping build, the
// opcode class in DECODE so an unknown opcode can report completion there.
// Optional feature macro: ILLEGAL_TRAP_EN -- unknown opcodes park the FSM in
// HALT with bus.illegal high until reset.
// -----------------------------------------------------------------------------
module multicycle_control
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_control_if.master    bus
);

    localparam logic [3:0] FETCH     = S_FETCH;
    localparam logic [3:0] DECODE    = S_DECODE;
    localparam logic [3:0] MEM_ADDR  = S_MEM_ADDR;
    localparam logic [3:0] MEM_READ  = S_MEM_READ;
    localparam logic [3:0] MEM_WB    = S_MEM_WB;
    localparam logic [3:0] MEM_WRITE = S_MEM_WRITE;
    localparam logic [3:0] R_EXEC    = S_R_EXEC;
    localparam logic [3:0] R_WB      = S_R_WB;
    localparam logic [3:0] ADDI_EXEC = S_ADDI_EXEC;
    localparam logic [3:0] ADDI_WB   = S_ADDI_WB;
    localparam logic [3:0] BRANCH    = S_BRANCH;
    localparam logic [3:0] JUMP      = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] HALT      = S_HALT;
`endif

    logic [3:0] state;
    logic [3:0] nextState;
    iclass_e    iclass;

    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
`ifdef ILLEGAL_TRAP_EN
    logic       illegalOut;
`endif

    opcode_class uClass (
        .opcode (bus.opcode),
        .iclass (iclass)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            FETCH: begin
                if (bus.mem_ready) nextState = DECODE;
            end
            DECODE: begin
                case (iclass)
                    CLS_MEM:   nextState = MEM_ADDR;
                    CLS_RTYPE: nextState = R_EXEC;
                    CLS_ADDI:  nextState = ADDI_EXEC;
                    CLS_BEQ:   nextState = BRANCH;
                    CLS_JUMP:  nextState = JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:   nextState = HALT;
`else
                    default:   nextState = FETCH;
`endif
                endcase
            end
            // Opcode is held in the IR, so it still names lw or sw here.
            MEM_ADDR:  nextState = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ: begin
                if (bus.mem_ready) nextState = MEM_WB;
            end
            MEM_WB:    nextState = FETCH;
            MEM_WRITE: begin
                if (bus.mem_ready) nextState = FETCH;
            end
            R_EXEC:    nextState = R_WB;
            R_WB:      nextState = FETCH;
            ADDI_EXEC: nextState = ADDI_WB;
            ADDI_WB:   nextState = FETCH;
            BRANCH:    nextState = FETCH;
            JUMP:      nextState = FETCH;
`ifdef ILLEGAL_TRAP_EN
            HALT:      nextState = HALT;
`endif
            default:   nextState = FETCH;
        endcase
    end

    // Output decode. Everything defaults low; reset masks the whole decode so
    // no register, memory or PC write can leak through in the reset cycle.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_B;
        aluOp       = ALUOP_ADD;
        pcSource    = PCSRC_ALU;
        instrDone   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegalOut  = 1'b0;
`endif
        if (rst_n) begin
            case (state)
                FETCH: begin
                    // PC+4 is computed every FETCH cycle but only committed,
                    // together with the IR load, when the read completes.
                    memRead  = 1'b1;
                    aluSrcB  = SRCB_FOUR;
                    irWrite  = bus.mem_ready;
                    pcWrite  = bus.mem_ready;
                end
                DECODE: begin
                    // Branch target precomputed into ALUOut.
                    aluSrcB  = SRCB_IMM_SH2;
`ifndef ILLEGAL_TRAP_EN
                    // Unknown opcode finishes here as a NOP.
                    instrDone = (iclass == CLS_ILLEGAL);
`endif
                end
                MEM_ADDR: begin
                    aluSrcA  = 1'b1;
                    aluSrcB  = SRCB_IMM;
                end
                MEM_READ: begin
                    memRead  = 1'b1;
                    iorD     = 1'b1;
                end
                MEM_WB: begin
                    regWrite  = 1'b1;
                    memtoReg  = 1'b1;
                    instrDone = 1'b1;
                end
                MEM_WRITE: begin
                    memWrite  = 1'b1;
                    iorD      = 1'b1;
                    instrDone = bus.mem_ready;
                end
                R_EXEC: begin
                    aluSrcA  = 1'b1;
                    aluSrcB  = SRCB_B;
                    aluOp    = ALUOP_FUNCT;
                end
                R_WB: begin
                    regWrite  = 1'b1;
                    regDst    = 1'b1;
                    instrDone = 1'b1;
                end
                ADDI_EXEC: begin
                    aluSrcA  = 1'b1;
                    aluSrcB  = SRCB_IMM;
                end
                ADDI_WB: begin
                    regWrite  = 1'b1;
                    instrDone = 1'b1;
                end
                BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluSrcB     = SRCB_B;
                    aluOp       = ALUOP_SUB;
                    pcWriteCond = 1'b1;
                    pcSource    = PCSRC_ALUOUT;
                    instrDone   = 1'b1;
                end
                JUMP: begin
                    pcWrite   = 1'b1;
                    pcSource  = PCSRC_JUMP;
                    instrDone = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                HALT: begin
                    illegalOut = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign bus.PCWrite     = pcWrite;
    assign bus.PCWriteCond = pcWriteCond;
    assign bus.IorD        = iorD;
    assign bus.MemRead     = memRead;
    assign bus.MemWrite    = memWrite;
    assign bus.IRWrite     = irWrite;
    assign bus.MemtoReg    = memtoReg;
    assign bus.RegDst      = regDst;
    assign bus.RegWrite    = regWrite;
    assign bus.ALUSrcA     = aluSrcA;
    assign bus.ALUSrcB     = aluSrcB;
    assign bus.ALUOp       = aluOp;
    assign bus.PCSource    = pcSource;
    assign bus.instr_done  = instrDone;
    assign bus.dbgState    = state_e'(state);
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal     = illegalOut;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboarded bench for multicycle_control. Each instruction is expanded from
// a table of per-step strobe patterns into expected per-cycle output words
// (exp_q) plus an expected instruction latency (lat_q). A negedge monitor pops
// and compares. Works with or without ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_multicycle_control;
    import mips_pkg::*;

    localparam int W = 18;

    logic clk;
    logic rst_n;

    multicycle_control_if ifc ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           assertCount = 0;
    int           failCount   = 0;
    bit           running     = 1'b0;
    int           cycleCnt    = 0;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Output word: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    //   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
    //   instr_done, illegal}
    function automatic logic [W-1:0] vec(
        input bit pcw, input bit pcwc, input bit iord, input bit mr,
        input bit mw, input bit irw, input bit m2r, input bit rdst,
        input bit rw, input bit srca, input logic [1:0] srcb,
        input logic [1:0] aop, input logic [1:0] pcs, input bit done,
        input bit ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca,
                srcb, aop, pcs, done, ill};
    endfunction

    // Per-step expected strobes, straight from the step descriptions.
    function automatic logic [W-1:0] fetchV(input bit r);
        return vec(r,0,0,1,0,r,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    endfunction
    function automatic logic [W-1:0] decodeV(input bit done);
        return vec(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,done,0);
    endfunction
    function automatic logic [W-1:0] memAddrV();
        return vec(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    endfunction
    function automatic logic [W-1:0] memReadV();
        return vec(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    endfunction
    function automatic logic [W-1:0] memWbV();
        return vec(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
    endfunction
    function automatic logic [W-1:0] memWriteV(input bit r);
        return vec(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,r,0);
    endfunction
    function automatic logic [W-1:0] rExecV();
        return vec(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    endfunction
    function automatic logic [W-1:0] rWbV();
        return vec(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
    endfunction
    function automatic logic [W-1:0] addiWbV();
        return vec(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);
    endfunction
    function automatic logic [W-1:0] branchV();
        return vec(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    endfunction
    function automatic logic [W-1:0] jumpV();
        return vec(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
    endfunction
    function automatic logic [W-1:0] haltV();
        return vec(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);
    endfunction

    function automatic bit isLegal(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b001000 || op == 6'b000100 || op == 6'b000010;
    endfunction

    function automatic int baseLatency(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic doReset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rst_n         = 1'b0;
            ifc.opcode    = 6'($urandom);
            ifc.mem_ready = 1'($urandom);
            exp_q.push_back('0);
        end
    endtask

    // fw: FETCH wait cycles, mw: MEM_READ/MEM_WRITE wait cycles,
    // abortAt: number of cycles to run before reset (-1 = run to completion).
    task automatic runInstr(input logic [5:0] op, input int fw, input int mw,
                            input int abortAt);
        logic [W-1:0] vq[$];
        bit           rq[$];
        bit           halted = 1'b0;
        bit           aborted;
        int           lat;

        for (int i = 0; i < fw; i++) begin vq.push_back(fetchV(0)); rq.push_back(0); end
        vq.push_back(fetchV(1)); rq.push_back(1);
        vq.push_back(decodeV(!isLegal(op) && !TRAP)); rq.push_back(1'($urandom));
        lat = baseLatency(op) + fw;
        case (op)
            6'b100011: begin
                vq.push_back(memAddrV()); rq.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin vq.push_back(memReadV()); rq.push_back(0); end
                vq.push_back(memReadV()); rq.push_back(1);
                vq.push_back(memWbV()); rq.push_back(1'($urandom));
                lat += mw;
            end
            6'b101011: begin
                vq.push_back(memAddrV()); rq.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin vq.push_back(memWriteV(0)); rq.push_back(0); end
                vq.push_back(memWriteV(1)); rq.push_back(1);
                lat += mw;
            end
            6'b000000: begin
                vq.push_back(rExecV()); rq.push_back(1'($urandom));
                vq.push_back(rWbV()); rq.push_back(1'($urandom));
            end
            6'b001000: begin
                vq.push_back(memAddrV()); rq.push_back(1'($urandom));
                vq.push_back(addiWbV()); rq.push_back(1'($urandom));
            end
            6'b000100: begin vq.push_back(branchV()); rq.push_back(1'($urandom)); end
            6'b000010: begin vq.push_back(jumpV()); rq.push_back(1'($urandom)); end
            default: begin
                if (TRAP) begin
                    halted = 1'b1;
                    for (int i = 0; i < 4; i++) begin vq.push_back(haltV()); rq.push_back(1'($urandom)); end
                end
            end
        endcase

        aborted = (abortAt >= 0) && (abortAt < vq.size());
        if (!aborted && !halted) lat_q.push_back(lat);

        for (int i = 0; i < vq.size(); i++) begin
            if (aborted && i >= abortAt) break;
            @(posedge clk);
            #1;
            rst_n         = 1'b1;
            ifc.opcode    = halted && i >= 2 ? 6'($urandom) : op;
            ifc.mem_ready = rq[i];
            exp_q.push_back(vq[i]);
        end
        if (aborted || halted) doReset();
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [W-1:0] actual;
    always_comb begin
        actual = {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead,
                  ifc.MemWrite, ifc.IRWrite, ifc.MemtoReg, ifc.RegDst,
                  ifc.RegWrite, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUOp,
                  ifc.PCSource, ifc.instr_done,
`ifdef ILLEGAL_TRAP_EN
                  ifc.illegal
`else
                  1'b0
`endif
                 };
    end

    always @(negedge clk) begin
        if (running) begin
            logic [W-1:0] e;
            assertCount++;
            if (exp_q.size() == 0) begin
                failCount++;
                $display("FAIL strobes @%0t: actual %h, required an entry but queue empty", $time, actual);
            end else begin
                e = exp_q.pop_front();
                if (actual !== e) begin
                    failCount++;
                    $display("FAIL strobes @%0t: actual %h required %h (state %0d)", $time, actual, e, ifc.dbgState);
                end
            end
            if (!rst_n) begin
                cycleCnt = 0;
            end else begin
                cycleCnt++;
                if (ifc.instr_done === 1'b1) begin
                    assertCount++;
                    if (lat_q.size() == 0) begin
                        failCount++;
                        $display("FAIL latency @%0t: actual %0d cycles, no instruction expected to end", $time, cycleCnt);
                    end else begin
                        int el;
                        el = lat_q.pop_front();
                        if (cycleCnt != el) begin
                            failCount++;
                            $display("FAIL latency @%0t: actual %0d required %0d", $time, cycleCnt, el);
                        end
                    end
                    cycleCnt = 0;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failCount++;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        int         ab;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b001000; ops[4] = 6'b000100; ops[5] = 6'b000010;

        rst_n         = 1'b0;
        ifc.opcode    = '0;
        ifc.mem_ready = 1'b0;
        running       = 1'b1;

        doReset();
        runInstr(6'b100011, 0, 0, -1);   // lw, no waits
        runInstr(6'b101011, 0, 3, -1);   // sw, 3 write waits
        runInstr(6'b000100, 0, 0, -1);   // beq
        runInstr(6'b000000, 0, 0, -1);   // R-type
        runInstr(6'b000010, 0, 0, -1);   // j
        runInstr(6'b001000, 2, 0, -1);   // addi with fetch waits
        runInstr(6'b100011, 1, 3, 5);    // reset mid MEM_READ wait
        runInstr(6'b101011, 0, 3, 4);    // reset mid MEM_WRITE wait
        runInstr(6'b111111, 0, 0, -1);   // unknown opcode
        runInstr(6'b100011, 0, 2, -1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (isLegal(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 6)) : -1;
            runInstr(op, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0, ab);
        end

        @(negedge clk);
        #1;
        running = 1'b0;

        assertCount++;
        if (exp_q.size() != 0) begin
            failCount++;
            $display("FAIL drain_strobes: actual %0d entries left, required 0", exp_q.size());
        end
        assertCount++;
        if (lat_q.size() != 0) begin
            failCount++;
            $display("FAIL drain_latency: actual %0d instructions unfinished, required 0", lat_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath. It replaces the single-cycle opcode decoder with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. Its strobes drive the shared ALU, the unified instruction/data memory port, the register file and the PC. A ready handshake stretches the memory states so the block works with wait-stated memory.

## Interface
Parameters:
- none

Ports:
- clk  input  1  core clock; all state changes on the rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- opcode  input  6  instruction[31:26], taken from the instruction register
- mem_ready  input  1  memory has completed the current read or write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU zero (beq)
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead  output  1  memory read request, held until mem_ready
- MemWrite  output  1  memory write request, held until mem_ready
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  write-back source: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = use funct
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse on the final cycle of every instruction

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, HALT. HALT exists only when the Configuration macro is defined.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only in a cycle where mem_ready=1.
  - Stay in FETCH while mem_ready=0.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Branches on opcode:
  - lw or sw -> MEM_ADDR
  - R-type -> R_EXEC
  - addi -> ADDI_EXEC
  - beq -> BRANCH
  - j -> JUMP
  - any other opcode -> see Configuration
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- Any output not listed for a state is 0.
- instr_done is asserted in the last cycle of each instruction: MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, and MEM_WRITE qualified by mem_ready.

## Timing
- Reset: while rst_n=0 at a rising edge, the next state is FETCH. All outputs are forced to 0 combinationally while rst_n=0.
- The first MemRead occurs in the first cycle after rst_n rises.
- Reset asserted in any state, including mid-wait in MEM_READ or MEM_WRITE, aborts the instruction. No register or PC write occurs in the reset cycle.
- Outputs are decoded from the state register. The only combinational input qualifications are mem_ready (on IRWrite, PCWrite in FETCH, and instr_done) and rst_n.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each wait cycle (mem_ready=0 in FETCH, MEM_READ or MEM_WRITE) adds exactly one cycle.
- MemRead and MemWrite stay asserted and stable across wait cycles.
- mem_ready is ignored in all other states.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE goes to HALT.
  - Adds output illegal (1 bit), high in HALT.
  - HALT asserts no other strobe and is left only by reset.
- ILLEGAL_TRAP_EN undefined:
  - An unknown opcode in DECODE returns to FETCH, behaving as a 2-cycle NOP, and pulses instr_done.
  - No illegal port.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - the ALUOp and ALUSrcB/PCSource encodings
  - the state enum type
- One combinational sub-module, opcode_class, maps opcode to an instruction-class code used for DECODE branching.
- The FSM register and output decode live in multicycle_control.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random opcode -> every output is 0. After release, FETCH asserts MemRead=1 and ALUSrcB=01.
- lw (opcode 100011) with mem_ready=1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. RegWrite=1 and MemtoReg=1 in cycle 5. instr_done pulses once.
- sw with mem_ready held 0 for 3 cycles in MEM_WRITE -> MemWrite stays 1 for 4 cycles. Total 7 cycles. No RegWrite.
- beq (000100) -> PCWriteCond=1, ALUOp=01, PCSource=01 in cycle 3, then FETCH.
- R-type followed by j (000010) -> R_WB asserts RegDst=1, RegWrite=1 (4 cycles). JUMP asserts PCWrite=1, PCSource=10 (3 cycles).
- Opcode 111111:
  - with ILLEGAL_TRAP_EN -> illegal=1 and stuck in HALT until rst_n=0.
  - without -> back to FETCH after DECODE with instr_done pulsed.
